// File: rtl/noc_axi4_bridge_deser_if.sv
// ---------------------------------------------------------------------------
// noc_axi4_bridge_deser_if
//   Bundles the NoC flit input handshake and the assembled-packet output
//   handshake of the request-side deserializer.
//
//   flit_in      NoC flit (NOC_DATA_WIDTH)
//   flit_in_val  flit valid
//   flit_in_rdy  flit accepted when flit_in_val & flit_in_rdy
//   header_out   header flits 0..2 concatenated, flit0 in LSBs
//   data_out     data flit k at [k*NOC_DATA_WIDTH +: NOC_DATA_WIDTH]
//   out_val      assembled packet valid
//   out_rdy      consumer accepts when out_val & out_rdy
//
//   slave  : the deserializer's view
//   master : the view of whoever drives flits and consumes packets
// ---------------------------------------------------------------------------
interface noc_axi4_bridge_deser_if #(
    parameter int NOC_DATA_WIDTH   = 64,
    parameter int AXI4_DATA_WIDTH  = 512,
    parameter int MSG_HEADER_WIDTH = 192
);
    logic [NOC_DATA_WIDTH-1:0]   flit_in;
    logic                        flit_in_val;
    logic                        flit_in_rdy;
    logic [MSG_HEADER_WIDTH-1:0] header_out;
    logic [AXI4_DATA_WIDTH-1:0]  data_out;
    logic                        out_val;
    logic                        out_rdy;

    modport slave (
        input  flit_in, flit_in_val, out_rdy,
        output flit_in_rdy, header_out, data_out, out_val
    );

    modport master (
        output flit_in, flit_in_val, out_rdy,
        input  flit_in_rdy, header_out, data_out, out_val
    );
endinterface

// File: rtl/noc_axi4_bridge_deser.sv
// ---------------------------------------------------------------------------
// noc_axi4_bridge_deser
//   Request-side deserializer of the NoC-to-AXI4 bridge. Collects one NoC
//   request packet (header flits followed by optional data flits) and
//   presents header and store data as one parallel word to the AXI4
//   request logic. Exactly one packet is buffered at a time.
//
//   clk     clock
//   rst_n   asynchronous active-low reset
//   bus     noc_axi4_bridge_deser_if.slave
//             flit_in/flit_in_val/flit_in_rdy  : NoC input handshake
//             header_out/data_out/out_val/out_rdy : assembled packet output
//
//   SWAP_ENDIANESS = 1 byte-reverses every data flit before it is stored;
//   header flits are always stored as received.
// ---------------------------------------------------------------------------
module noc_axi4_bridge_deser #(
    parameter int NOC_DATA_WIDTH   = 64,
    parameter int AXI4_DATA_WIDTH  = 512,
    parameter int MSG_HEADER_WIDTH = 192,
    parameter int MSG_LENGTH_LO    = 22,
    parameter int MSG_LENGTH_WIDTH = 8,
    parameter bit SWAP_ENDIANESS   = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    noc_axi4_bridge_deser_if.slave  bus
);

    localparam int NUM_SLOTS = AXI4_DATA_WIDTH / NOC_DATA_WIDTH;
    localparam int NUM_HDR   = MSG_HEADER_WIDTH / NOC_DATA_WIDTH;
    localparam int NUM_BYTES = NOC_DATA_WIDTH / 8;
    localparam int SLOT_W    = $clog2(NUM_SLOTS) + 1;
    localparam int HDR_W     = $clog2(NUM_HDR + 1);

    typedef enum logic [1:0] {
        ST_HDR  = 2'd0,
        ST_DATA = 2'd1,
        ST_SEND = 2'd2
    } state_t;

    state_t                      state;
    state_t                      state_next;

    logic [MSG_HEADER_WIDTH-1:0] header_q;
    logic [AXI4_DATA_WIDTH-1:0]  data_q;
    logic [HDR_W-1:0]            hdr_cnt;     // header flits accepted so far
    logic [SLOT_W-1:0]           slot;        // next data slot, saturates at NUM_SLOTS
    logic [MSG_LENGTH_WIDTH-1:0] remaining;   // flits still expected after the current one

    logic                        flit_rdy;
    logic                        pkt_val;
    logic                        flit_fire;
    logic                        slot_full;
    logic [MSG_LENGTH_WIDTH-1:0] flit_len;
    logic [NOC_DATA_WIDTH-1:0]   data_flit;

    function automatic logic [NOC_DATA_WIDTH-1:0] byte_swap(
        input logic [NOC_DATA_WIDTH-1:0] w
    );
        logic [NOC_DATA_WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_BYTES; i++) begin
            r[i*8 +: 8] = w[(NUM_BYTES-1-i)*8 +: 8];
        end
        return r;
    endfunction

    assign flit_fire = bus.flit_in_val & flit_rdy;
    assign flit_len  = bus.flit_in[MSG_LENGTH_LO +: MSG_LENGTH_WIDTH];
    assign slot_full = (slot == SLOT_W'(NUM_SLOTS));
    assign data_flit = SWAP_ENDIANESS ? byte_swap(bus.flit_in) : bus.flit_in;

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge value of every other flop, independent of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_HDR;
        end else begin
            state <= state_next;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next-state logic
    //   A packet is 1+L flits, L taken from flit0. In HDR the packet can end
    //   on any header flit; a nonzero remaining count at the last header flit
    //   moves on to DATA.
    // -----------------------------------------------------------------------
    // NOTE: state_next gets a default before the case so no path leaves it
    // unassigned; otherwise a latch would be inferred.
    always_comb begin
        state_next = state;
        unique case (state)
            ST_HDR: begin
                if (flit_fire) begin
                    if (hdr_cnt == '0) begin
                        if (flit_len == '0) begin
                            state_next = ST_SEND;
                        end
                    end else if (remaining == MSG_LENGTH_WIDTH'(1)) begin
                        state_next = ST_SEND;
                    end else if (hdr_cnt == HDR_W'(NUM_HDR - 1)) begin
                        state_next = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (flit_fire && remaining == MSG_LENGTH_WIDTH'(1)) begin
                    state_next = ST_SEND;
                end
            end
            ST_SEND: begin
                if (bus.out_rdy) begin
                    state_next = ST_HDR;
                end
            end
            default: state_next = ST_HDR;
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: outputs, decoded from state only
    // -----------------------------------------------------------------------
    always_comb begin
        flit_rdy = (state != ST_SEND);
        pkt_val  = (state == ST_SEND);
    end

    assign bus.flit_in_rdy = flit_rdy;
    assign bus.out_val     = pkt_val;
    assign bus.header_out  = header_q;
    assign bus.data_out    = data_q;

    // -----------------------------------------------------------------------
    // Datapath: header/data capture and flit counters
    // -----------------------------------------------------------------------
    // NOTE: the wide header/data registers are reset as well: unused slots of
    // short packets must read 0, and a reset mid-packet must drop partial data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            header_q  <= '0;
            data_q    <= '0;
            hdr_cnt   <= '0;
            slot      <= '0;
            remaining <= '0;
        end else begin
            unique case (state)
                ST_HDR: begin
                    if (flit_fire) begin
                        header_q[int'(hdr_cnt)*NOC_DATA_WIDTH +: NOC_DATA_WIDTH] <= bus.flit_in;
                        hdr_cnt   <= hdr_cnt + HDR_W'(1);
                        remaining <= (hdr_cnt == '0) ? flit_len
                                                     : remaining - MSG_LENGTH_WIDTH'(1);
                    end
                end
                ST_DATA: begin
                    if (flit_fire) begin
                        // Flits beyond the last slot are accepted but dropped.
                        if (!slot_full) begin
                            data_q[int'(slot)*NOC_DATA_WIDTH +: NOC_DATA_WIDTH] <= data_flit;
                            slot <= slot + SLOT_W'(1);
                        end
                        remaining <= remaining - MSG_LENGTH_WIDTH'(1);
                    end
                end
                ST_SEND: begin
                    if (bus.out_rdy) begin
                        header_q  <= '0;
                        data_q    <= '0;
                        hdr_cnt   <= '0;
                        slot      <= '0;
                        remaining <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
